// File: rtl/uart_pkg.sv
// Shared definitions for the 7-bit even-parity UART link (DTE transmitter and line receiver).
package uart_pkg;

    localparam int unsigned DATA_BITS            = 7;
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 521;  // 10 MHz / 19200 baud

    // State encoding shared with the DTE UART transmitter
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        StIdle   = ST_IDLE,
        StStart  = ST_START,
        StData   = ST_DATA,
        StParity = ST_PARITY,
        StStop   = ST_STOP
    } uart_state_e;

    // Even parity: the parity bit equals the XOR of the data bits
    function automatic logic even_parity7(input logic [6:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus a falling-edge detector.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_in,
    output logic rx_sync,
    output logic fall
);

    logic sync1_q, sync2_q, prev_q;

    // Flops reset high so an idle line never looks like a start edge out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rx_sync = sync2_q;
    assign fall    = prev_q & ~sync2_q;

endmodule

// File: rtl/uart_line_rx.sv
// UART line receiver: 7 data bits, even parity, one stop bit, single-entry holding register.
module uart_line_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 rx_busy
);

    localparam logic [10:0] HALF_END = 11'((CLKS_PER_BIT >> 1) - 1);
    localparam logic [10:0] BIT_END  = 11'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_IDX = 3'(DATA_BITS - 1);

    uart_state_e          state_q;
    logic [10:0]          cnt_q;
    logic [2:0]           idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parity_q;

    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q, perr_q, ferr_q, ovr_q;

    logic line, fall;
    logic frame_done, handshake;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx_in   (rx_in),
        .rx_sync (line),
        .fall    (fall)
    );

    // The stop bit is sampled straight from the synchronized line in this cycle
    assign frame_done = (state_q == StStop) && (cnt_q == BIT_END);
    assign handshake  = valid_q && rx_ready;

    // Frame sequencer: start-bit qualification at half period, then one sample per bit period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    // Only a 1->0 transition starts a frame, so a held-low break cannot retrigger
                    if (fall) begin
                        state_q <= StStart;
                        cnt_q   <= '0;
                    end
                end
                StStart: begin
                    if (cnt_q == HALF_END) begin
                        cnt_q <= '0;
                        idx_q <= '0;
                        state_q <= line ? StIdle : StData;
                    end else begin
                        cnt_q <= cnt_q + 11'd1;
                    end
                end
                StData: begin
                    if (cnt_q == BIT_END) begin
                        shift_q[idx_q] <= line;
                        cnt_q          <= '0;
                        if (idx_q == LAST_IDX) begin
                            state_q <= StParity;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 11'd1;
                    end
                end
                StParity: begin
                    if (cnt_q == BIT_END) begin
                        parity_q <= line;
                        cnt_q    <= '0;
                        state_q  <= StStop;
                    end else begin
                        cnt_q <= cnt_q + 11'd1;
                    end
                end
                StStop: begin
                    if (cnt_q == BIT_END) begin
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 11'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Holding register: a completed frame is dropped (overrun) only if the old one is not leaving
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (frame_done) begin
                if (!valid_q || rx_ready) begin
                    data_q  <= shift_q;
                    perr_q  <= even_parity7(shift_q) ^ parity_q;
                    ferr_q  <= ~line;
                    valid_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (handshake) begin
                valid_q <= 1'b0;
            end
            if (handshake) begin
                ovr_q <= 1'b0;
            end
        end
    end

    assign rx_data       = data_q;
    assign rx_valid      = valid_q;
    assign rx_parity_err = perr_q;
    assign rx_frame_err  = ferr_q;
    assign rx_overrun    = ovr_q;
    assign rx_busy       = (state_q != StIdle);

endmodule

// File: doc/uart_line_rx.md
# uart_line_rx

Standalone UART line receiver for the far end of the 7-bit, even-parity serial link driven by the team's DTE UART transmitter. It oversamples the asynchronous line on the system clock, samples each bit at mid-period, checks parity and stop bit, and presents each received character through a single-entry valid/ready holding register. Errors and overruns are reported to the consuming logic.

## Interface
- `CLKS_PER_BIT`, 521: clocks per bit period (10 MHz / 19200 baud); legal range 4..2047.
- `DATA_BITS`, 7: data bits per frame; fixed at 7 in this revision.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_in`  in  1  serial line, asynchronous to `clk`; idles high.
- `rx_data`  out  7  received character, valid while `rx_valid`.
- `rx_valid`  out  1  holding register full.
- `rx_ready`  in  1  consumer accepts; transfer occurs when `rx_valid && rx_ready`.
- `rx_parity_err`  out  1  parity mismatch for the held character; qualified by `rx_valid`.
- `rx_frame_err`  out  1  stop bit sampled low for the held character; qualified by `rx_valid`.
- `rx_overrun`  out  1  sticky: a frame completed while the register was full and not being read.
- `rx_busy`  out  1  FSM not in IDLE.

## Operation
- Frame on the line: start bit (0), d0..d6 LSB first, parity bit, one stop bit (1). Even parity: the parity bit equals the XOR of d0..d6.
- `rx_in` passes through a 2-FF synchronizer (both flops reset to 1). A previous-value flop provides falling-edge detection.
- FSM states: IDLE, START, DATA, PARITY, STOP. A single 11-bit counter `cnt` and a 3-bit index `idx` serve all states.
- IDLE → START on a synchronized falling edge; `cnt` is set to 0. A line held low (break) does not retrigger the FSM.
- START: `cnt` increments each cycle. At `cnt == (CLKS_PER_BIT>>1)-1` the line is sampled:
  - low → DATA, with `cnt`=0 and `idx`=0;
  - high → glitch; return to IDLE with no output.
- DATA: at `cnt == CLKS_PER_BIT-1`, shift[idx] takes the line and `cnt` resets to 0. When `idx==6`, go to PARITY; otherwise increment `idx`.
- PARITY: at `cnt == CLKS_PER_BIT-1`, capture the parity bit; `cnt` resets to 0; go to STOP.
- STOP: at `cnt == CLKS_PER_BIT-1`, sample the stop bit, complete the frame, and go to IDLE.
- Frame completion with the holding register empty, or being read in the same cycle:
  - load `rx_data` with the shift register;
  - set `rx_parity_err` to `^shift ^ parity_bit`;
  - set `rx_frame_err` to the inverted stop sample;
  - set `rx_valid` to 1.
- Frame completion while `rx_valid && !rx_ready`: the new frame is dropped, the old contents are kept, and `rx_overrun` is set to 1.
- A handshake with no simultaneous completion clears `rx_valid` on the next edge. Any handshake clears `rx_overrun`.
- A framing error still returns the FSM to IDLE. A new frame needs a fresh falling edge.

## Timing
- Reset values: `rx_data` 0, `rx_valid` 0, `rx_parity_err` 0, `rx_frame_err` 0, `rx_overrun` 0, `rx_busy` 0; FSM in IDLE; synchronizer flops 1.
- Reset asserted mid-frame aborts the frame immediately. No partial data is ever presented.
- Edge-detect latency: 3 clocks after the `rx_in` fall, counting the 2 synchronizer flops plus the edge flop.
- `rx_valid` rises 1 clock after the stop sample. The stop sample falls (CLKS_PER_BIT>>1) + 9·CLKS_PER_BIT clocks after START entry; for the default that is 260 + 4689.
- `rx_busy` deasserts on the same edge that `rx_valid` asserts.
- `rx_ready` may be held high permanently, giving zero-bubble acceptance.

## Structure
- Shared package `uart_pkg` holds:
  - state encoding localparams (IDLE/START/DATA/PARITY/STOP), shared with the DTE UART;
  - `DATA_BITS`;
  - the default `CLKS_PER_BIT`;
  - a parity function `even_parity7`.
- One sub-module, `uart_rx_sync`: 2-FF synchronizer plus falling-edge detector. Its output is the synchronized level and a 1-cycle `fall` pulse.

## Test plan
Bench uses `CLKS_PER_BIT`=16 unless noted.
- Send 0x2A with parity 1 and stop 1 → `rx_data`=0x2A, `rx_valid`=1, `rx_parity_err`=0, `rx_frame_err`=0, latency exact per Timing.
- Send 0x7F with parity 0 → `rx_parity_err`=1, `rx_data`=0x7F. Send 0x00 with stop bit 0 → `rx_frame_err`=1, and no retrigger while the line is held low.
- Low glitch of 3 clocks on an idle line → FSM back to IDLE, `rx_valid` stays 0, `rx_busy` pulses only.
- `rx_ready`=0, send 0x11 then 0x22 → `rx_data` stays 0x11, `rx_overrun`=1. Assert `rx_ready` → valid drops and overrun clears.
- `rx_ready` held high, completion coinciding with the handshake → valid stays 1, new data loaded, no overrun.
- Assert `rst_n`=0 during DATA bit 3, release, then send 0x55 → clean reset values, then 0x55 received correctly. Repeat with the default 521 at one frame.
